// File: rtl/alarm_cmd_ctrl.sv
// Host command parser for the alarm clock: decodes 'l'/'a' + four BCD digits + CR,
// toggles alarm enable on '@', and echoes accepted bytes (or '?') to the UART.
module alarm_cmd_ctrl #(
  parameter int TIMEOUT_CYC = 12000000,
  parameter int CNT_W       = 24
) (
  input  logic       clk12m,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_data_rdy,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_data_rdy,
  output logic       ld_time,
  output logic       ld_alarm,
  output logic [3:0] dig_mt,
  output logic [3:0] dig_mo,
  output logic [3:0] dig_st,
  output logic [3:0] dig_so,
  output logic       alarm_en,
  output logic       cmd_err,
  output logic       busy
);

  localparam logic [7:0]       CH_L    = 8'h6c;
  localparam logic [7:0]       CH_LU   = 8'h4c;
  localparam logic [7:0]       CH_A    = 8'h61;
  localparam logic [7:0]       CH_AU   = 8'h41;
  localparam logic [7:0]       CH_AT   = 8'h40;
  localparam logic [7:0]       CH_CR   = 8'h0d;
  localparam logic [7:0]       CH_QM   = 8'h3f;
  localparam logic [7:0]       CH_0    = 8'h30;
  localparam logic [7:0]       CH_5    = 8'h35;
  localparam logic [7:0]       CH_9    = 8'h39;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_DIG = 2'd1,
    ST_WAIT_CR = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            tgt_alarm_q, tgt_alarm_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]      buf_q, buf_d;
  logic            buf_vld_q, buf_vld_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_data_rdy_q, tx_data_rdy_d;
  logic            ld_time_q, ld_time_d;
  logic            ld_alarm_q, ld_alarm_d;
  logic            alarm_en_q, alarm_en_d;
  logic            cmd_err_q, cmd_err_d;
  logic            busy_q, busy_d;
  logic            echo_s, err_s, timeout_s, digit_ok_s;
  logic [7:0]      echo_byte_s;

  // Next-state logic for the parser, timeout counter and echo buffer
  always_comb begin
    state_d       = state_q;
    tgt_alarm_d   = tgt_alarm_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    dig_d         = dig_q;
    buf_d         = buf_q;
    buf_vld_d     = buf_vld_q;
    tx_data_d     = tx_data_q;
    tx_data_rdy_d = 1'b0;
    ld_time_d     = 1'b0;
    ld_alarm_d    = 1'b0;
    alarm_en_d    = alarm_en_q;
    cmd_err_d     = 1'b0;
    echo_s        = 1'b0;
    err_s         = 1'b0;
    echo_byte_s   = rx_data;
    // Even index = tens digit (0-5), odd index = ones digit (0-9)
    digit_ok_s    = (rx_data >= CH_0) && (rx_data <= (idx_q[0] ? CH_9 : CH_5));
    timeout_s     = (state_q != ST_IDLE) && !rx_data_rdy && (cnt_q == TO_LAST);

    case (state_q)
      ST_IDLE: begin
        if (!rx_data_rdy) begin
          state_d = ST_IDLE;
        end else if (rx_data == CH_L || rx_data == CH_LU) begin
          tgt_alarm_d = 1'b0;
          idx_d       = 2'd0;
          state_d     = ST_GET_DIG;
          echo_s      = 1'b1;
        end else if (rx_data == CH_A || rx_data == CH_AU) begin
          tgt_alarm_d = 1'b1;
          idx_d       = 2'd0;
          state_d     = ST_GET_DIG;
          echo_s      = 1'b1;
        end else if (rx_data == CH_AT) begin
          alarm_en_d = ~alarm_en_q;
          echo_s     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GET_DIG: begin
        if (!rx_data_rdy) begin
          state_d = ST_GET_DIG;
        end else if (digit_ok_s) begin
          // ASCII '0'-'9' minus 8'h30 is just the low nibble
          shadow_d[idx_q] = rx_data[3:0];
          idx_d           = idx_q + 2'd1;
          echo_s          = 1'b1;
          if (idx_q == 2'd3) begin
            state_d = ST_WAIT_CR;
          end else begin
            state_d = ST_GET_DIG;
          end
        end else begin
          err_s = 1'b1;
        end
      end
      ST_WAIT_CR: begin
        if (!rx_data_rdy) begin
          state_d = ST_WAIT_CR;
        end else if (rx_data == CH_CR) begin
          dig_d      = shadow_q;
          ld_time_d  = ~tgt_alarm_q;
          ld_alarm_d = tgt_alarm_q;
          state_d    = ST_IDLE;
          echo_s     = 1'b1;
        end else begin
          err_s = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (err_s || timeout_s) begin
      cmd_err_d = 1'b1;
      state_d   = ST_IDLE;
      idx_d     = 2'd0;
      shadow_d  = '0;
    end else begin
      cmd_err_d = 1'b0;
    end

    if (err_s) begin
      echo_s      = 1'b1;
      echo_byte_s = CH_QM;
    end else begin
      echo_byte_s = rx_data;
    end

    if (rx_data_rdy || state_q == ST_IDLE || timeout_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A full buffer drains first; any echo arriving meanwhile is dropped
    if (buf_vld_q) begin
      if (!tx_busy) begin
        tx_data_d     = buf_q;
        tx_data_rdy_d = 1'b1;
        buf_vld_d     = 1'b0;
      end else begin
        buf_vld_d = 1'b1;
      end
    end else if (echo_s) begin
      if (!tx_busy) begin
        tx_data_d     = echo_byte_s;
        tx_data_rdy_d = 1'b1;
      end else begin
        buf_d     = echo_byte_s;
        buf_vld_d = 1'b1;
      end
    end else begin
      buf_vld_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk12m or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tgt_alarm_q   <= 1'b0;
      idx_q         <= 2'd0;
      shadow_q      <= '0;
      dig_q         <= '0;
      cnt_q         <= '0;
      buf_q         <= 8'h00;
      buf_vld_q     <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_data_rdy_q <= 1'b0;
      ld_time_q     <= 1'b0;
      ld_alarm_q    <= 1'b0;
      alarm_en_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_alarm_q   <= tgt_alarm_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      dig_q         <= dig_d;
      cnt_q         <= cnt_d;
      buf_q         <= buf_d;
      buf_vld_q     <= buf_vld_d;
      tx_data_q     <= tx_data_d;
      tx_data_rdy_q <= tx_data_rdy_d;
      ld_time_q     <= ld_time_d;
      ld_alarm_q    <= ld_alarm_d;
      alarm_en_q    <= alarm_en_d;
      cmd_err_q     <= cmd_err_d;
      busy_q        <= busy_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_data_rdy = tx_data_rdy_q;
  assign ld_time     = ld_time_q;
  assign ld_alarm    = ld_alarm_q;
  assign dig_mt      = dig_q[0];
  assign dig_mo      = dig_q[1];
  assign dig_st      = dig_q[2];
  assign dig_so      = dig_q[3];
  assign alarm_en    = alarm_en_q;
  assign cmd_err     = cmd_err_q;
  assign busy        = busy_q;

endmodule
